// File: rtl/pp_mult_sequencer.sv
// ============================================================================
// pp_mult_sequencer
// ----------------------------------------------------------------------------
// Purpose:
//   Sequential unsigned shift-and-add multiplier. An operand pair is captured
//   on the input handshake. One partial product per clock is then added into a
//   2*WIDTH accumulator. The finished product is held on P until the consumer
//   accepts it.
//
//   State flow: IDLE -> ACCUM -> DONE -> IDLE
//     IDLE  : in_ready=1, waiting for an operand pair
//     ACCUM : one multiplier bit consumed per cycle
//     DONE  : out_valid=1, P=product, held until out_ready
//
// Ports:
//   clk        in   1        rising-edge clock for all state
//   rst        in   1        synchronous active-high reset
//   in_valid   in   1        operand pair A/B presented
//   in_ready   out  1        operands can be accepted (IDLE only)
//   A          in   WIDTH    multiplicand, sampled on input handshake
//   B          in   WIDTH    multiplier, sampled on input handshake
//   out_valid  out  1        P holds a completed product
//   out_ready  in   1        consumer accepts P
//   P          out  2*WIDTH  unsigned product A*B, zero outside DONE
//   busy       out  1        high in ACCUM or DONE
//
// Configuration macro:
//   ZERO_SKIP_EN - when defined, ACCUM ends as soon as no set multiplier bits
//                  remain above the current index. This shortens the run for
//                  small multipliers. When undefined, ACCUM always lasts
//                  exactly WIDTH cycles, whatever the operand values.
// ============================================================================
module pp_mult_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] P,
    output logic               busy
);

    localparam int              IDXW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t               state;
    state_t               next_state;

    logic [WIDTH-1:0]     a_r;
    logic [WIDTH-1:0]     b_r;
    logic [2*WIDTH-1:0]   acc;
    logic [IDXW-1:0]      idx;

    logic [2*WIDTH-1:0]   partial;
    logic                 last_step;
    logic                 take_in;

    // Input handshake. in_ready depends only on the state, so no comb loop
    // goes through in_valid.
    assign take_in = in_valid && in_ready;

    // Partial product for the current multiplier bit, aligned to its weight.
    // The running sum is bounded by (2^WIDTH-1)^2, which always fits in
    // 2*WIDTH bits. The accumulator therefore can never wrap.
    always_comb begin
        partial = {{WIDTH{1'b0}}, a_r & {WIDTH{b_r[idx]}}} << idx;
    end

`ifdef ZERO_SKIP_EN
    logic [WIDTH-1:0] b_rest;

    // Early exit: once every multiplier bit above idx is zero, the remaining
    // partial products contribute nothing. At least one ACCUM cycle is still
    // spent, so B=0 finishes after idx 0 with a zero product.
    always_comb begin
        b_rest    = b_r >> idx;
        last_step = (idx == LAST_IDX) || ((b_rest >> 1) == '0);
    end
`else
    // Fixed-length run: every bit position is visited, so operands such as 0
    // or all-ones take exactly the same number of cycles as any other value.
    always_comb begin
        last_step = (idx == LAST_IDX);
    end
`endif

    // State register. Reset returns to IDLE, which discards any product in
    // flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. in_valid is only looked at in IDLE and out_ready only
    // in DONE. Strobes on either signal in any other state have no effect.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (take_in) begin
                    next_state = ACCUM;
                end
            end
            ACCUM: begin
                if (last_step) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Datapath registers. Operands are frozen once captured, so a new in_valid
    // during ACCUM or DONE cannot disturb a product in progress. The
    // accumulator is left alone in DONE, which keeps P stable under
    // backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r <= '0;
            b_r <= '0;
            acc <= '0;
            idx <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (take_in) begin
                        a_r <= A;
                        b_r <= B;
                        acc <= '0;
                        idx <= '0;
                    end
                end
                ACCUM: begin
                    acc <= acc + partial;
                    idx <= last_step ? '0 : idx + IDXW'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // Output decode. P is forced to zero outside DONE so that a consumer
    // never sees a partial sum.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        P         = '0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
            end
            ACCUM: begin
                busy = 1'b1;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                P         = acc;
            end
            default: begin
            end
        endcase
    end

    // Protocol invariants: the block never offers and accepts at the same
    // time, and a stalled product stays valid and unchanged.
    a_no_overlap: assert property (@(posedge clk) !(in_ready && out_valid));

    a_hold_stable: assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |=> (out_valid && $stable(P)));

endmodule

// File: tb/tb_pp_mult_sequencer.sv
// ============================================================================
// tb_pp_mult_sequencer
// ----------------------------------------------------------------------------
// Self-checking bench for pp_mult_sequencer (WIDTH=8).
//
// A driver issues operand pairs and, on each accepted handshake, pushes the
// expected product, the handshake edge and the expected ACCUM length into a
// queue. A monitor samples the DUT once per cycle and maintains its own
// idle/busy model. Whenever out_valid is shown, the monitor pops the queue
// and compares the product and its arrival cycle.
// ============================================================================
module tb_pp_mult_sequencer;

    localparam int WIDTH = 8;
`ifdef ZERO_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   p;
    logic                 busy;

    typedef struct {
        logic [2*WIDTH-1:0] prod;
        int                 hsEdge;
        int                 accCycles;
    } exp_t;

    exp_t sbQueue[$];

    int cyc       = 0;
    int checks    = 0;
    int failures  = 0;
    bit inFlight  = 1'b0;
    bit seenValid = 1'b0;
    bit prevHeld  = 1'b0;
    int lastHs    = 0;
    int lastAcc   = 0;

    pp_mult_sequencer #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (a),
        .B         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .P         (p),
        .busy      (busy)
    );

    // 10 ns clock. cyc equals k between rising edge k and rising edge k+1.
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
    end

    // Overall time limit so that the run can never hang.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "[TB] watchdog expired");
    end

    // One comparison. It counts the check and reports any difference.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Expected ACCUM length for multiplier bv.
    function automatic int accCyclesFor(input logic [WIDTH-1:0] bv);
        int msb = 0;
        for (int i = 0; i < WIDTH; i++) begin
            if (bv[i]) msb = i;
        end
        return SKIP ? msb + 1 : WIDTH;
    endfunction

    // Present one pair and wait a bounded time until it is accepted. When hold
    // is set, in_valid stays high afterwards, so that the next call runs
    // back-to-back. That next call also changes A/B while the DUT is busy.
    task automatic applyStimulus(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                 input logic [2*WIDTH-1:0] expP, input bit hold);
        int waitCycles = 0;
        int hs;
        int acc;
        @(negedge clk);
        in_valid = 1'b1;
        a        = av;
        b        = bv;
        while (!in_ready && waitCycles < 50) begin
            @(negedge clk);
            waitCycles++;
        end
        if (!in_ready) begin
            checkOutput("accept_timeout", in_ready, 1);
            in_valid = 1'b0;
            prevHeld = 1'b0;
            return;
        end
        hs  = cyc + 1;
        acc = accCyclesFor(bv);
        sbQueue.push_back('{prod: expP, hsEdge: hs, accCycles: acc});
        if (hold && prevHeld) begin
            checkOutput("throughput", hs - lastHs, lastAcc + 2);
        end
        prevHeld = hold;
        lastHs   = hs;
        lastAcc  = acc;
        if (!hold) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    // Wait a bounded time until every expected product has been consumed.
    task automatic waitDrain();
        int n = 0;
        while ((sbQueue.size() != 0 || inFlight) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sbQueue.size() != 0 || inFlight) begin
            checkOutput("drain_timeout", sbQueue.size(), 0);
        end
        prevHeld = 1'b0;
    endtask

    // Monitor. It samples 1 ns after each falling edge, so DUT outputs and TB
    // inputs for the next rising edge are both settled.
    always @(negedge clk) begin
        #1;
        checkOutput("in_ready", in_ready, !inFlight);
        checkOutput("busy", busy, inFlight);
        if (out_valid) begin
            if (sbQueue.size() == 0) begin
                checkOutput("out_valid_unexpected", out_valid, 0);
            end else begin
                checkOutput("P", p, sbQueue[0].prod);
                if (!seenValid) begin
                    checkOutput("latency", cyc, sbQueue[0].hsEdge + sbQueue[0].accCycles);
                    seenValid = 1'b1;
                end
                if (out_ready && !rst) begin
                    void'(sbQueue.pop_front());
                    seenValid = 1'b0;
                    inFlight  = 1'b0;
                end
            end
        end else begin
            checkOutput("P_zero", p, 0);
            if (inFlight && sbQueue.size() != 0 &&
                cyc >= sbQueue[0].hsEdge + sbQueue[0].accCycles) begin
                checkOutput("out_valid_late", out_valid, 1);
            end
        end
        if (rst) begin
            sbQueue.delete();
            inFlight  = 1'b0;
            seenValid = 1'b0;
        end else if (in_valid && in_ready) begin
            inFlight = 1'b1;
        end
    end

    typedef struct {
        logic [WIDTH-1:0]   av;
        logic [WIDTH-1:0]   bv;
        logic [2*WIDTH-1:0] prod;
    } vec_t;

    vec_t b2bVecs[$] = '{
        '{av: 8'h00, bv: 8'hFF, prod: 16'h0000},
        '{av: 8'hFF, bv: 8'h00, prod: 16'h0000},
        '{av: 8'h80, bv: 8'h80, prod: 16'h4000},
        '{av: 8'h01, bv: 8'hFF, prod: 16'h00FF},
        '{av: 8'hAA, bv: 8'h55, prod: 16'h3872},
        '{av: 8'hFF, bv: 8'h01, prod: 16'h00FF}
    };

    initial begin
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        int               n;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;

        // Reset state.
        repeat (3) @(negedge clk);
        checkOutput("reset_in_ready", in_ready, 1);
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_P", p, 0);
        rst = 1'b0;

        // Largest operands with a free-running consumer.
        $display("[TB] max operands");
        applyStimulus(8'hFF, 8'hFF, 16'hFE01, 1'b0);
        waitDrain();

        // Small multiplier, then a zero multiplier.
        $display("[TB] small and zero multiplier");
        applyStimulus(8'h0F, 8'h03, 16'h002D, 1'b0);
        waitDrain();
        applyStimulus(8'h25, 8'h00, 16'h0000, 1'b0);
        waitDrain();

        // Backpressure, with ignored in_valid pulses while busy.
        $display("[TB] backpressure");
        out_ready = 1'b0;
        applyStimulus(8'h12, 8'h34, 16'h03A8, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            a        = 8'h01;
            b        = 8'h01;
            @(negedge clk);
            in_valid = 1'b0;
        end
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("bp_out_valid", out_valid, 1);
        repeat (5) @(negedge clk);
        out_ready = 1'b1;
        waitDrain();

        // Reset at the 4th ACCUM cycle discards the product.
        $display("[TB] reset mid-accumulate");
        applyStimulus(8'hFF, 8'hFF, 16'hFE01, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("post_rst_in_ready", in_ready, 1);
        checkOutput("post_rst_out_valid", out_valid, 0);
        checkOutput("post_rst_P", p, 0);
        repeat (12) @(negedge clk);
        applyStimulus(8'h03, 8'h05, 16'h000F, 1'b0);
        waitDrain();

        // Back-to-back, directed table then random pairs, in_valid held.
        $display("[TB] back-to-back");
        foreach (b2bVecs[i]) begin
            applyStimulus(b2bVecs[i].av, b2bVecs[i].bv, b2bVecs[i].prod, 1'b1);
        end
        for (int i = 0; i < 1000; i++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            applyStimulus(ra, rb, (2*WIDTH)'(ra) * (2*WIDTH)'(rb), 1'b1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        waitDrain();

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
